// File: rtl/fft_pingpong_loader_if.sv
// Sample-stream, core-read and frame hand-over signals of the ping-pong FFT loader.
// The producer/core side uses the master modport; the loader uses slave.
interface fft_pingpong_loader_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_LOG2N = 12
);
    logic [3:0]           log2n;
    logic                 bitrev_en;
    logic [DATA_W-1:0]    wdata;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           wburst;
    logic                 rd_en;
    logic [MAX_LOG2N-1:0] rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 frame_rdy;
    logic                 frame_bank;
    logic [3:0]           frame_log2n;
    logic                 frame_done;
    logic [1:0]           err;

    modport master (
        output log2n, bitrev_en, wdata, wvalid, wburst, rd_en, rd_addr, frame_done,
        input  wready, rd_data, frame_rdy, frame_bank, frame_log2n, err
    );

    modport slave (
        input  log2n, bitrev_en, wdata, wvalid, wburst, rd_en, rd_addr, frame_done,
        output wready, rd_data, frame_rdy, frame_bank, frame_log2n, err
    );
endinterface

// File: rtl/fft_pingpong_loader.sv
// Two-bank ping-pong sample loader: frames stream into one bank (optionally bit-reversed)
// while the FFT core reads the other; banks cycle EMPTY -> FILL -> FULL -> CORE -> EMPTY.
module fft_pingpong_loader #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_LOG2N = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_pingpong_loader_if.slave io_bus
);

    localparam int unsigned Depth    = 1 << MAX_LOG2N;
    localparam logic [3:0]  MaxLog2n = 4'(MAX_LOG2N);

    typedef enum logic [1:0] {StWaitSof, StFilling, StStall} wr_st_e;
    typedef enum logic [1:0] {BkEmpty, BkFill, BkFull, BkCore} bank_st_e;

    wr_st_e               r_state, w_state_d;
    bank_st_e             r_bank_st [2];
    bank_st_e             w_bank_st_d [2];
    logic [MAX_LOG2N-1:0] r_cnt, w_cnt_d;
    logic [3:0]           r_log2n, w_log2n_d;
    logic                 r_bitrev, w_bitrev_d;
    logic                 r_fill_bank, w_fill_bank_d;
    logic [3:0]           r_bank_log2n [2];
    logic                 r_older;
    logic                 r_frame_rdy;
    logic                 r_frame_bank;
    logic [3:0]           r_frame_log2n;
    logic [1:0]           r_err, w_err_d;
    logic [DATA_W-1:0]    r_rd_data;
    logic [DATA_W-1:0]    r_mem [2][Depth];

    logic                 w_wready;
    logic                 w_beat;
    logic                 w_sof;
    logic                 w_eof;
    logic                 w_legal;
    logic [3:0]           w_shamt;
    logic [MAX_LOG2N-1:0] w_last;
    logic [MAX_LOG2N-1:0] w_rev;
    logic [MAX_LOG2N-1:0] w_wr_addr;
    logic [MAX_LOG2N-1:0] w_we_addr;
    logic                 w_we;
    logic                 w_start;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_free_bank;
    logic                 w_any_empty;
    logic                 w_other_empty;
    logic                 w_full0;
    logic                 w_full1;
    logic                 w_release;
    logic                 w_handover;
    logic                 w_ho_bank;

    assign w_beat        = io_bus.wvalid & w_wready;
    assign w_sof         = io_bus.wburst[0];
    assign w_eof         = io_bus.wburst[1];
    assign w_legal       = (io_bus.log2n != 4'd0) && (io_bus.log2n <= MaxLog2n);
    assign w_shamt       = MaxLog2n - r_log2n;
    assign w_last        = {MAX_LOG2N{1'b1}} >> w_shamt;
    assign w_free_bank   = (r_bank_st[0] == BkEmpty) ? 1'b0 : 1'b1;
    assign w_any_empty   = (r_bank_st[0] == BkEmpty) || (r_bank_st[1] == BkEmpty);
    assign w_other_empty = (r_bank_st[~r_fill_bank] == BkEmpty);
    assign w_full0       = (r_bank_st[0] == BkFull);
    assign w_full1       = (r_bank_st[1] == BkFull);

    // Full-width reversal shifted down equals reversal over the low LOG2N bits, since cnt < 2^LOG2N
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            w_rev[i] = r_cnt[MAX_LOG2N-1-i];
        end
    end

    assign w_wr_addr = r_bitrev ? (w_rev >> w_shamt) : r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StWaitSof;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_log2n_d     = r_log2n;
        w_bitrev_d    = r_bitrev;
        w_fill_bank_d = r_fill_bank;
        w_err_d       = 2'b00;
        w_we          = 1'b0;
        w_we_addr     = w_wr_addr;
        w_start       = 1'b0;
        w_done        = 1'b0;
        w_abort       = 1'b0;
        unique case (r_state)
            StWaitSof: begin
                if (w_beat) begin
                    if (!w_sof) begin
                        w_err_d[0] = 1'b1;
                    end else if (!w_legal) begin
                        w_err_d[1] = 1'b1;
                    end else if (w_eof) begin
                        w_err_d[0] = 1'b1;
                    end else begin
                        w_start       = 1'b1;
                        w_fill_bank_d = w_free_bank;
                        w_log2n_d     = io_bus.log2n;
                        w_bitrev_d    = io_bus.bitrev_en;
                        w_cnt_d       = {{(MAX_LOG2N-1){1'b0}}, 1'b1};
                        w_we          = 1'b1;
                        w_we_addr     = '0;
                        w_state_d     = StFilling;
                    end
                end
            end
            StFilling: begin
                if (w_beat) begin
                    if (w_sof) begin
                        // Mid-frame SOF restarts in the same bank when it is itself a valid start
                        w_err_d[0] = 1'b1;
                        if (w_legal && !w_eof) begin
                            w_log2n_d  = io_bus.log2n;
                            w_bitrev_d = io_bus.bitrev_en;
                            w_cnt_d    = {{(MAX_LOG2N-1){1'b0}}, 1'b1};
                            w_we       = 1'b1;
                            w_we_addr  = '0;
                        end else begin
                            w_err_d[1] = !w_legal;
                            w_abort    = 1'b1;
                            w_cnt_d    = '0;
                            w_state_d  = StWaitSof;
                        end
                    end else if (w_eof != (r_cnt == w_last)) begin
                        w_err_d[0] = 1'b1;
                        w_abort    = 1'b1;
                        w_cnt_d    = '0;
                        w_state_d  = StWaitSof;
                    end else if (w_eof) begin
                        w_we      = 1'b1;
                        w_done    = 1'b1;
                        w_cnt_d   = '0;
                        w_state_d = w_other_empty ? StWaitSof : StStall;
                    end else begin
                        w_we    = 1'b1;
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StStall: begin
                if (w_any_empty) begin
                    w_state_d = StWaitSof;
                end
            end
            default: w_state_d = StWaitSof;
        endcase
    end

    always_comb begin
        w_wready = 1'b0;
        if (!rst && (r_state != StStall)) begin
            w_wready = 1'b1;
        end
    end

    // Release wins over hand-over, so the next FULL bank is handed over one edge later
    always_comb begin
        w_bank_st_d = r_bank_st;
        w_release   = r_frame_rdy & io_bus.frame_done;
        w_handover  = 1'b0;
        w_ho_bank   = 1'b0;
        if (w_release) begin
            w_bank_st_d[r_frame_bank] = BkEmpty;
        end else if (!r_frame_rdy && (w_full0 || w_full1)) begin
            w_handover = 1'b1;
            w_ho_bank  = w_full1 ? (w_full0 ? r_older : 1'b1) : 1'b0;
            w_bank_st_d[w_ho_bank] = BkCore;
        end
        if (w_start) begin
            w_bank_st_d[w_fill_bank_d] = BkFill;
        end
        if (w_abort) begin
            w_bank_st_d[r_fill_bank] = BkEmpty;
        end
        if (w_done) begin
            w_bank_st_d[r_fill_bank] = BkFull;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_st[0]    <= BkEmpty;
            r_bank_st[1]    <= BkEmpty;
            r_cnt           <= '0;
            r_log2n         <= 4'd0;
            r_bitrev        <= 1'b0;
            r_fill_bank     <= 1'b0;
            r_bank_log2n[0] <= 4'd0;
            r_bank_log2n[1] <= 4'd0;
            r_older         <= 1'b0;
            r_frame_rdy     <= 1'b0;
            r_frame_bank    <= 1'b0;
            r_frame_log2n   <= 4'd0;
            r_err           <= 2'b00;
        end else begin
            r_bank_st   <= w_bank_st_d;
            r_cnt       <= w_cnt_d;
            r_log2n     <= w_log2n_d;
            r_bitrev    <= w_bitrev_d;
            r_fill_bank <= w_fill_bank_d;
            r_err       <= w_err_d;
            if (w_done) begin
                r_bank_log2n[r_fill_bank] <= r_log2n;
                if (r_bank_st[~r_fill_bank] != BkFull) begin
                    r_older <= r_fill_bank;
                end
            end
            if (w_release) begin
                r_frame_rdy <= 1'b0;
            end else if (w_handover) begin
                r_frame_rdy   <= 1'b1;
                r_frame_bank  <= w_ho_bank;
                r_frame_log2n <= r_bank_log2n[w_ho_bank];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_fill_bank_d][w_we_addr] <= io_bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (io_bus.rd_en) begin
            r_rd_data <= r_mem[r_frame_bank][io_bus.rd_addr];
        end
    end

    assign io_bus.wready      = w_wready;
    assign io_bus.rd_data     = r_rd_data;
    assign io_bus.frame_rdy   = r_frame_rdy;
    assign io_bus.frame_bank  = r_frame_bank;
    assign io_bus.frame_log2n = r_frame_log2n;
    assign io_bus.err         = r_err;

endmodule

// File: tb/tb_fft_pingpong_loader.sv
// Directed bench for the ping-pong loader: bit-reversed load, back-pressure,
// framing/size errors and mid-frame reset, each against hand-computed values.
module tb_fft_pingpong_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fft_pingpong_loader_if #(.DATA_W(16), .MAX_LOG2N(12)) bus ();

    fft_pingpong_loader #(.DATA_W(16), .MAX_LOG2N(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [1:0] b);
        int n = 0;
        bus.wdata  = d;
        bus.wburst = b;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin
            tick(1);
            n++;
        end
        if (!bus.wready) check_eq("wready_timeout", 32'(bus.wready), 32'd1);
        tick(1);
        bus.wvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] l2, input logic br, input int base);
        int n = 1 << l2;
        bus.log2n     = l2;
        bus.bitrev_en = br;
        for (int i = 0; i < n; i++) begin
            send_beat(16'(base + i), {(i == n - 1), (i == 0)});
        end
    endtask

    task automatic read_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick(1);
        bus.rd_en = 1'b0;
        check_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic pulse_done();
        bus.frame_done = 1'b1;
        tick(1);
        bus.frame_done = 1'b0;
    endtask

    initial begin
        logic [15:0] rev_exp [8];
        rev_exp = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
        bus.log2n      = 4'd0;
        bus.bitrev_en  = 1'b0;
        bus.wdata      = '0;
        bus.wvalid     = 1'b0;
        bus.wburst     = 2'b00;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.frame_done = 1'b0;

        // Reset state
        tick(2);
        check_eq("rst_wready", 32'(bus.wready), 32'd0);
        check_eq("rst_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        check_eq("rst_frame_bank", 32'(bus.frame_bank), 32'd0);
        check_eq("rst_frame_log2n", 32'(bus.frame_log2n), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_wready", 32'(bus.wready), 32'd1);
        tick(1);

        // Bit-reversed 8-point frame
        send_frame(4'd3, 1'b1, 0);
        check_eq("br_rdy_pre", 32'(bus.frame_rdy), 32'd0);
        tick(1);
        check_eq("br_rdy", 32'(bus.frame_rdy), 32'd1);
        check_eq("br_bank", 32'(bus.frame_bank), 32'd0);
        check_eq("br_log2n", 32'(bus.frame_log2n), 32'd3);
        for (int a = 0; a < 8; a++) begin
            read_chk($sformatf("br_rd%0d", a), 12'(a), rev_exp[a]);
        end
        tick(2);
        check_eq("rd_hold", 32'(bus.rd_data), 32'd7);
        pulse_done();
        check_eq("br_release", 32'(bus.frame_rdy), 32'd0);

        // Early EOF on the 5th beat of an 8-point frame
        bus.log2n     = 4'd3;
        bus.bitrev_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_beat(16'(50 + i), {(i == 4), (i == 0)});
        end
        check_eq("early_eof_err", 32'(bus.err), 32'd1);
        tick(1);
        check_eq("early_eof_err_clr", 32'(bus.err), 32'd0);
        tick(3);
        check_eq("early_eof_no_rdy", 32'(bus.frame_rdy), 32'd0);
        send_frame(4'd3, 1'b0, 100);
        tick(1);
        check_eq("good_rdy", 32'(bus.frame_rdy), 32'd1);
        check_eq("good_bank", 32'(bus.frame_bank), 32'd0);
        read_chk("good_rd0", 12'd0, 16'd100);
        read_chk("good_rd5", 12'd5, 16'd105);
        read_chk("good_rd7", 12'd7, 16'd107);
        pulse_done();

        // Missing EOF on the last beat, and SOF+EOF on one beat
        bus.log2n = 4'd1;
        send_beat(16'd1, 2'b01);
        send_beat(16'd2, 2'b00);
        check_eq("miss_eof_err", 32'(bus.err), 32'd1);
        send_beat(16'd3, 2'b11);
        check_eq("sof_eof_err", 32'(bus.err), 32'd1);

        // Illegal sizes; a following non-SOF beat proves WAIT_SOF was kept
        bus.log2n = 4'd13;
        send_beat(16'd9, 2'b01);
        check_eq("size13_err", 32'(bus.err), 32'd2);
        send_beat(16'd9, 2'b00);
        check_eq("size13_waitsof", 32'(bus.err), 32'd1);
        bus.log2n = 4'd0;
        send_beat(16'd9, 2'b01);
        check_eq("size0_err", 32'(bus.err), 32'd2);
        tick(2);
        check_eq("err_idle", 32'(bus.err), 32'd0);

        // Three back-to-back 4-point frames with release withheld
        send_frame(4'd2, 1'b0, 16);
        send_frame(4'd2, 1'b0, 32);
        check_eq("bb_stall", 32'(bus.wready), 32'd0);
        check_eq("bb_rdy0", 32'(bus.frame_rdy), 32'd1);
        check_eq("bb_bank0", 32'(bus.frame_bank), 32'd0);
        read_chk("bb_rd_f1", 12'd2, 16'd18);
        tick(3);
        check_eq("bb_stall_hold", 32'(bus.wready), 32'd0);
        pulse_done();
        check_eq("bb_gap", 32'(bus.frame_rdy), 32'd0);
        tick(1);
        check_eq("bb_rdy1", 32'(bus.frame_rdy), 32'd1);
        check_eq("bb_bank1", 32'(bus.frame_bank), 32'd1);
        check_eq("bb_log2n", 32'(bus.frame_log2n), 32'd2);
        check_eq("bb_wready_back", 32'(bus.wready), 32'd1);
        read_chk("bb_rd_f2", 12'd3, 16'd35);
        send_frame(4'd2, 1'b0, 48);
        check_eq("bb_stall2", 32'(bus.wready), 32'd0);
        pulse_done();
        tick(1);
        check_eq("bb_bank_f3", 32'(bus.frame_bank), 32'd0);
        read_chk("bb_rd_f3", 12'd1, 16'd49);
        pulse_done();

        // Reset during the 3rd beat of a 16-point frame while the other bank is with the core
        tick(2);
        send_frame(4'd2, 1'b0, 200);
        tick(1);
        check_eq("mr_core", 32'(bus.frame_rdy), 32'd1);
        bus.log2n     = 4'd4;
        bus.bitrev_en = 1'b0;
        send_beat(16'd250, 2'b01);
        send_beat(16'd251, 2'b00);
        bus.wdata  = 16'd252;
        bus.wburst = 2'b00;
        bus.wvalid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check_eq("mr_rdy_now", 32'(bus.frame_rdy), 32'd0);
        check_eq("mr_wready_rst", 32'(bus.wready), 32'd0);
        bus.wvalid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mr_wready_rel", 32'(bus.wready), 32'd1);
        check_eq("mr_bank_rst", 32'(bus.frame_bank), 32'd0);
        tick(1);
        send_frame(4'd4, 1'b0, 300);
        tick(1);
        check_eq("mr_rdy", 32'(bus.frame_rdy), 32'd1);
        check_eq("mr_bank", 32'(bus.frame_bank), 32'd0);
        check_eq("mr_log2n", 32'(bus.frame_log2n), 32'd4);
        read_chk("mr_rd0", 12'd0, 16'd300);
        read_chk("mr_rd15", 12'd15, 16'd315);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
